// File: rtl/id_decode_lmsm.sv
// id_decode_lmsm: IITB RISC decode stage with LM/SM micro-op expansion
module id_decode_lmsm #(
    parameter logic [3:0] LM_OPCODE = 4'b0110,
    parameter logic [3:0] SM_OPCODE = 4'b0111
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [15:0] in_instr,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [18:0] out_data,
    output logic        lmsm_busy
);
    typedef enum logic {IDLE, EXPAND} state_t;
    state_t      state_q, state_d;
    logic        out_valid_q, out_valid_d;
    logic [18:0] out_data_q, out_data_d;
    logic [7:0]  mask_q, mask_d;
    logic [2:0]  base_q, base_d;
    logic [2:0]  offset_q, offset_d;
    logic        is_sm_q, is_sm_d;
    logic        adv, accept, expanding, uop_load;
    logic [3:0]  opc;
    logic [7:0]  src_mask, rem_mask;
    logic [2:0]  src_base, src_off, idx;
    logic        src_sm;
    logic [18:0] dec_word, uop;

    assign opc       = in_instr[15:12];
    assign expanding = (state_q == EXPAND);
    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = !expanding && adv && !flush && resetn;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign lmsm_busy = expanding;

    // Plain decode of non-LM/SM instructions; unknown opcodes decode to NOP
    always_comb begin
        dec_word = '0;
        case (opc)
            4'b0001, 4'b0010:
                dec_word = {in_instr[5:3], in_instr[11:9], in_instr[8:6], 1'b0, in_instr[1:0], opc, 1'b0, 2'b11};
            4'b0000, 4'b0100, 4'b0101, 4'b1000:
                dec_word = {in_instr[8:6], in_instr[11:9], in_instr[5:0], opc, 1'b0, 2'b10};
            4'b1010:
                dec_word = {in_instr[11:9], in_instr[8:6], 6'd0, opc, 1'b0, 2'b10};
            4'b0011, 4'b1001:
                dec_word = {in_instr[11:9], in_instr[8:0], opc, 1'b0, 2'b01};
            default:
                dec_word = '0;
        endcase
    end

    assign src_mask = expanding ? mask_q : in_instr[7:0];
    assign src_base = expanding ? base_q : in_instr[11:9];
    assign src_off  = expanding ? offset_q : 3'd0;
    assign src_sm   = expanding ? is_sm_q : (opc == SM_OPCODE);
    assign rem_mask = src_mask & (src_mask - 8'd1);
    assign uop      = {idx, src_base, 3'b000, src_off, src_sm ? 4'b0101 : 4'b0100, rem_mask == 8'd0, 2'b10};
    assign uop_load = (expanding && adv) ||
                      (accept && (opc == LM_OPCODE || opc == SM_OPCODE) && in_instr[7:0] != 8'd0);

    // Lowest set mask bit selects the register of the next micro-op
    always_comb begin
        idx = '0;
        for (int i = 7; i >= 0; i--)
            if (src_mask[i]) idx = 3'(i);
    end

    // Next output word and LM/SM sequencing state
    always_comb begin
        state_d     = state_q;
        out_valid_d = adv ? 1'b0 : out_valid_q;
        out_data_d  = out_data_q;
        mask_d      = mask_q;
        base_d      = base_q;
        offset_d    = offset_q;
        is_sm_d     = is_sm_q;
        if (uop_load) begin
            out_valid_d = 1'b1;
            out_data_d  = uop;
            mask_d      = rem_mask;
            base_d      = src_base;
            offset_d    = src_off + 3'd1;
            is_sm_d     = src_sm;
            state_d     = (rem_mask != 8'd0) ? EXPAND : IDLE;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = dec_word;
        end
    end

    // Registers; reset and flush both abort any expansion and empty the output
    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            mask_q      <= '0;
            base_q      <= '0;
            offset_q    <= '0;
            is_sm_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            mask_q      <= mask_d;
            base_q      <= base_d;
            offset_q    <= offset_d;
            is_sm_q     <= is_sm_d;
        end
    end
endmodule
